// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: funct codes, FSM states and the operation decode shared by the HI/LO unit.
package mul_div_unit_pkg;
    localparam logic [5:0] FUN_MFHI  = 6'h10;
    localparam logic [5:0] FUN_MFLO  = 6'h12;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic is_md(input logic [5:0] f);
        return f == FUN_MULT || f == FUN_MULTU || f == FUN_DIV || f == FUN_DIVU;
    endfunction
endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU producing HI/LO over 32 shift-add / restoring-subtract cycles.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             writeLoHi,
    output logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] writeDataHi
);
    localparam logic [5:0] ITERS = 6'(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d, a_q, a_d, lo_q, lo_d, hi_q, hi_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               mul_q, mul_d, neg_q, neg_d, sa_q, sa_d, dz_q, dz_d;
    logic               sgn, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [WIDTH:0]     alu;
    logic [2*WIDTH-1:0] prod;

    assign sgn    = funct == FUN_MULT || funct == FUN_DIV;
    assign sign_a = sgn & operandA[WIDTH-1];
    assign sign_b = sgn & operandB[WIDTH-1];
    assign mag_a  = sign_a ? -operandA : operandA;
    assign mag_b  = sign_b ? -operandB : operandB;

    // One adder serves both: add multiplicand to the high half, or trial-subtract divisor from the shifted remainder.
    assign alu  = mul_q ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q}
                        : acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (start && is_md(funct)) begin
                state_d = RUN;
                mul_d   = funct == FUN_MULT || funct == FUN_MULTU;
                neg_d   = sign_a ^ sign_b;
                sa_d    = sign_a;
                dz_d    = operandB == '0;
                a_d     = operandA;
                m_d     = mul_d ? mag_a : mag_b;
                acc_d   = {{WIDTH{1'b0}}, mul_d ? mag_b : mag_a};
                cnt_d   = '0;
            end
            RUN: if (cnt_q == ITERS) begin
                state_d = DONE;
                lo_d    = mul_q ? prod[WIDTH-1:0] : dz_q ? '1 : quo;
                hi_d    = mul_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : rem;
            end else begin
                cnt_d = cnt_q + 6'd1;
                acc_d = mul_q ? (acc_q[0] ? {alu, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]})
                              : (alu[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                            : {alu[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1});
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign writeLoHi   = state_q == DONE;
    assign writeData   = lo_q;
    assign writeDataHi = hi_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h0;
    logic [31:0] operandA = 32'h0;
    logic [31:0] operandB = 32'h0;
    logic        busy, writeLoHi;
    logic [31:0] writeData, writeDataHi;
    logic [31:0] rf_hi, rf_lo;
    int          n_cmp = 0;
    int          n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .operandA(operandA), .operandB(operandB), .busy(busy),
        .writeLoHi(writeLoHi), .writeData(writeData), .writeDataHi(writeDataHi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            rf_hi <= 32'h0;
            rf_lo <= 32'h0;
        end else if (writeLoHi) begin
            rf_hi <= writeDataHi;
            rf_lo <= writeData;
        end
    end

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        logic [63:0] q, r;
        if ((f == F_DIV || f == F_DIVU) && b == 32'h0) return {a, 32'hFFFFFFFF};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, scrambles inputs after acceptance, reports pulse latency, results and post-pulse busy/pulse state.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo, output int extra);
        funct = f; operandA = a; operandB = b; start = 1'b1;
        tick();
        start = 1'b0; funct = 6'($urandom); operandA = $urandom; operandB = $urandom;
        lat = -1; hi = 'x; lo = 'x;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (writeLoHi) begin
                lat = k; hi = writeDataHi; lo = writeData;
            end
        end
        tick();
        extra = int'(writeLoHi) + int'(busy);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_cmp += 4;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        if (writeLoHi !== 1'b0) begin n_err++; $display("FAIL reset_wlohi got %b want 0", writeLoHi); end
        if (writeData !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", writeData); end
        if (writeDataHi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", writeDataHi); end
    endtask

    task automatic test_directed();
        logic [5:0]  tf [8] = '{F_MULTU, F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV, F_DIV, F_DIVU};
        logic [31:0] ta [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00010000, 32'hFFFFFFF9,
                                32'hDEAD0000, 32'h20200523, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] tb [8] = '{32'hFFFFFFFF, 32'h5, 32'h0000DEAD, 32'h2, 32'h10, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] eh [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h20200523, 32'h0, 32'hFFFFFFF9};
        logic [31:0] el [8] = '{32'h00000001, 32'hFFFFFFF1, 32'hDEAD0000, 32'hFFFFFFFD, 32'h0DEAD000,
                                32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        int lat, extra;
        logic [31:0] hi, lo;
        for (int i = 0; i < 8; i++) begin
            run_op(tf[i], ta[i], tb[i], lat, hi, lo, extra);
            n_cmp += 4;
            if (lat !== 33) begin n_err++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
            if (hi !== eh[i]) begin n_err++; $display("FAIL dir%0d_hi got %h want %h", i, hi, eh[i]); end
            if (lo !== el[i]) begin n_err++; $display("FAIL dir%0d_lo got %h want %h", i, lo, el[i]); end
            if (extra !== 0) begin n_err++; $display("FAIL dir%0d_after got busy+wlohi=%0d want 0", i, extra); end
        end
    endtask

    task automatic test_busy_window();
        int bad = 0;
        funct = F_MULTU; operandA = 32'h7; operandB = 32'h9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (busy !== 1'b1) bad++;
            if (writeLoHi !== (k == 34)) bad++;
            tick();
        end
        n_cmp += 2;
        if (bad !== 0) begin n_err++; $display("FAIL busy_window got %0d bad cycles want 0", bad); end
        if (busy !== 1'b0 || writeLoHi !== 1'b0)
            begin n_err++; $display("FAIL busy_release got busy=%b wlohi=%b want 0 0", busy, writeLoHi); end
    endtask

    task automatic test_random();
        logic [5:0]  fs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [31:0] sp [4] = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF};
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int lat, extra;
        for (int i = 0; i < 60; i++) begin
            f = fs[$urandom_range(0, 3)];
            a = ($urandom_range(0, 5) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 5) == 0) ? sp[$urandom_range(0, 3)] : ($urandom >> $urandom_range(0, 31));
            exp = model(f, a, b);
            run_op(f, a, b, lat, hi, lo, extra);
            n_cmp += 3;
            if (lat !== 33) begin n_err++; $display("FAIL rnd%0d_latency got %0d want 33", i, lat); end
            if ({hi, lo} !== exp)
                begin n_err++; $display("FAIL rnd%0d f=%h a=%h b=%h got %h_%h want %h", i, f, a, b, hi, lo, exp); end
            if (extra !== 0) begin n_err++; $display("FAIL rnd%0d_after got %0d want 0", i, extra); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1, pulses = 0;
        logic [31:0] hi, lo;
        funct = F_DIVU; operandA = 32'hDEAD0000; operandB = 32'h10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        funct = F_MULTU; operandA = 32'h2; operandB = 32'h3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 6; k <= 80; k++) begin
            tick();
            if (writeLoHi) begin
                pulses++;
                if (lat < 0) begin lat = k; hi = writeDataHi; lo = writeData; end
            end
        end
        n_cmp += 4;
        if (lat !== 33) begin n_err++; $display("FAIL ignore_latency got %0d want 33", lat); end
        if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        if (lo !== 32'h0DEAD000) begin n_err++; $display("FAIL ignore_lo got %h want 0dead000", lo); end
        if (hi !== 32'h0) begin n_err++; $display("FAIL ignore_hi got %h want 0", hi); end
    endtask

    task automatic test_bad_funct();
        int seen = 0;
        funct = F_MFHI; operandA = 32'h5; operandB = 32'h6; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL badfunct_busy got %b want 0", busy); end
        for (int k = 0; k < 40; k++) begin
            tick();
            seen += int'(writeLoHi) + int'(busy);
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL badfunct_activity got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen = 0, lat, extra;
        logic [31:0] hi, lo;
        funct = F_MULT; operandA = 32'h12345678; operandB = 32'h9ABCDEF0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b want 0", busy); end
        if (writeLoHi !== 1'b0) begin n_err++; $display("FAIL midreset_wlohi got %b want 0", writeLoHi); end
        if ({writeDataHi, writeData} !== 64'h0)
            begin n_err++; $display("FAIL midreset_out got %h_%h want 0", writeDataHi, writeData); end
        for (int k = 0; k < 40; k++) begin
            tick();
            seen += int'(writeLoHi);
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL midreset_pulse got %0d want 0", seen); end
        reset = 1'b1; start = 1'b1; funct = F_MULTU;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_busy got %b want 0", busy); end
        run_op(F_MULTU, 32'h2, 32'h3, lat, hi, lo, extra);
        n_cmp += 2;
        if (lo !== 32'h6) begin n_err++; $display("FAIL postreset_lo got %h want 6", lo); end
        if (hi !== 32'h0) begin n_err++; $display("FAIL postreset_hi got %h want 0", hi); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int lat, extra;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            exp = model(i[0] ? F_DIV : F_MULT, a, b);
            run_op(i[0] ? F_DIV : F_MULT, a, b, lat, hi, lo, extra);
            n_cmp++;
            if ({hi, lo} !== exp || lat !== 33)
                begin n_err++; $display("FAIL b2b%0d got %h_%h lat %0d want %h lat 33", i, hi, lo, lat, exp); end
        end
    endtask

    task automatic test_regfile();
        int lat, extra;
        logic [31:0] hi, lo;
        run_op(F_MULTU, 32'hDEADDEAD, 32'h1, lat, hi, lo, extra);
        n_cmp += 2;
        if (rf_lo !== 32'hDEADDEAD) begin n_err++; $display("FAIL mflo_mul got %h want deaddead", rf_lo); end
        if (rf_hi !== 32'h0) begin n_err++; $display("FAIL mfhi_mul got %h want 0", rf_hi); end
        run_op(F_DIVU, 32'hBEEFBEEF, 32'h10000, lat, hi, lo, extra);
        n_cmp += 2;
        if (rf_lo !== 32'hBEEF) begin n_err++; $display("FAIL mflo_div got %h want beef", rf_lo); end
        if (rf_hi !== 32'hBEEF) begin n_err++; $display("FAIL mfhi_div got %h want beef", rf_hi); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_window();
        test_random();
        test_ignore_start();
        test_bad_funct();
        test_reset_mid();
        test_back_to_back();
        test_regfile();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
